// File: rtl/alu_pkg.sv
// Shared ALU definitions.
//   alu_op_t      : op tag carried alongside an ALU result
//   stage_state_t : occupancy state of the ALU result stage
//   ALU_N         : ALU datapath width
package alu_pkg;

  localparam int ALU_N = 32;

  typedef enum logic [3:0] {
    ALU_AND = 4'h0,
    ALU_OR  = 4'h1,
    ALU_ADD = 4'h2,
    ALU_SUB = 4'h3
  } alu_op_t;

  // EMPTY: no entry; ONE: main entry valid; TWO: main and skid entries valid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational result-flag generator.
//   f    : in  [N-1:0] result to inspect
//   zero : out         1 when f is all zeros
//   neg  : out         sign bit of f (two's complement)
module alu_flag_gen #(
  parameter int N = 32
) (
  input  logic [N-1:0] f,
  output logic         zero,
  output logic         neg
);

  assign zero = (f == {N{1'b0}});
  assign neg  = f[N-1];

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage behind the ALU function units. Captures the ALU
// result and its op tag, derives zero/negative flags at capture time, and
// hands entries to the consumer through a two-entry skid buffer.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : producer handshake, F and in_op are the payload
//   out_valid/out_ready   : consumer handshake
//   out_result/out_op     : captured result and op tag (main entry)
//   out_zero/out_neg      : flags computed from F when it was captured
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The sender keeps valid and payload stable until it transfers;
// ready may be high without valid. in_ready and out_valid are decoded from
// the state register only, so no input reaches them combinationally.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int N    = ALU_N,
  parameter int OP_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    F,
  input  logic [OP_W-1:0] in_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_result,
  output logic [OP_W-1:0] out_op,
  output logic            out_zero,
  output logic            out_neg
);

  stage_state_t state;

  // Main entry drives out_*; skid holds the one extra result accepted
  // while the consumer stalls.
  logic [N-1:0]    main_result, skid_result;
  logic [OP_W-1:0] main_op,     skid_op;
  logic            main_zero,   skid_zero;
  logic            main_neg,    skid_neg;

  logic f_zero, f_neg;
  logic push, pop;

  alu_flag_gen #(.N(N)) u_flag_gen (
    .f    (F),
    .zero (f_zero),
    .neg  (f_neg)
  );

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_result = main_result;
  assign out_op     = main_op;
  assign out_zero   = main_zero;
  assign out_neg    = main_neg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      main_result <= '0;
      main_op     <= '0;
      main_zero   <= 1'b0;
      main_neg    <= 1'b0;
      skid_result <= '0;
      skid_op     <= '0;
      skid_zero   <= 1'b0;
      skid_neg    <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            main_result <= F;
            main_op     <= in_op;
            main_zero   <= f_zero;
            main_neg    <= f_neg;
            state       <= ONE;
          end
        end
        ONE: begin
          if (push && !pop) begin
            // Consumer stalled: park the new result behind the main entry.
            skid_result <= F;
            skid_op     <= in_op;
            skid_zero   <= f_zero;
            skid_neg    <= f_neg;
            state       <= TWO;
          end else if (push && pop) begin
            // Main entry leaves this edge, so the new result replaces it.
            main_result <= F;
            main_op     <= in_op;
            main_zero   <= f_zero;
            main_neg    <= f_neg;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            main_result <= skid_result;
            main_op     <= skid_op;
            main_zero   <= skid_zero;
            main_neg    <= skid_neg;
            state       <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;
  import alu_pkg::*;

  localparam int W = 4 + 32 + 2;  // {op, result, zero, neg}

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] F;
  logic [3:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_op;
  logic        out_zero;
  logic        out_neg;

  logic [W-1:0] exp_q[$];
  int n_vec;
  int n_fail;
  int ready_drops;
  logic rand_done;

  alu_result_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .F          (F),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_op     (out_op),
    .out_zero   (out_zero),
    .out_neg    (out_neg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, exp_q size %0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] mk_exp(input logic [31:0] f, input logic [3:0] op);
    return {op, f, (f == 32'd0), f[31]};
  endfunction

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(input logic [31:0] f, input logic [3:0] op);
    int guard;
    in_valid = 1'b1;
    F        = f;
    in_op    = op;
    guard    = 0;
    while (!in_ready && guard < 1000) begin
      ready_drops++;
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      check("send_timeout", 64'(in_ready), 64'd1);
    end else begin
      exp_q.push_back(mk_exp(f, op));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    F        = $urandom;  // payload is don't-care while in_valid=0
    in_op    = 4'($urandom_range(0, 15));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic         prev_hold;
  logic [W-1:0] prev_out;

  always @(negedge clk) begin
    logic [W-1:0] cur;
    logic [W-1:0] e;
    cur = {out_op, out_result, out_zero, out_neg};
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) check("hold_stable", 64'(cur), 64'(prev_out));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'(cur), 64'd0);
          n_fail += (cur == '0) ? 1 : 0;  // an output with nothing expected is always an error
        end else begin
          e = exp_q.pop_front();
          check("sb_result", 64'(cur), 64'(e));
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_out  = cur;
    end
  end

  // ---------------- random out_ready ----------------
  initial begin
    wait (rand_done === 1'b0);
    @(posedge rand_done or negedge rand_done);
  end

  // ---------------- stimulus ----------------
  initial begin
    n_vec       = 0;
    n_fail      = 0;
    ready_drops = 0;
    rand_done   = 1'b1;
    prev_hold   = 1'b0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    F           = '0;
    in_op       = '0;
    out_ready   = 1'b0;

    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_outputs",   64'({out_op, out_result, out_zero, out_neg}), 64'd0);
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Single: 14 & 2 = 2
    out_ready = 1'b1;
    send(32'd2, ALU_AND);
    check("single_valid",  64'(out_valid),  64'd1);
    check("single_result", 64'(out_result), 64'd2);
    check("single_zero",   64'(out_zero),   64'd0);
    check("single_neg",    64'(out_neg),    64'd0);
    drain("single_drain");

    // Zero flag back-to-back: 1 & 2 = 0, 180 & 267 = 0
    send(32'd0, ALU_AND);
    check("zero1_flag", 64'(out_zero), 64'd1);
    send(32'd0, ALU_OR);
    check("zero2_flag", 64'(out_zero), 64'd1);
    check("zero2_op",   64'(out_op),   64'(ALU_OR));
    drain("zero_drain");

    // Backpressure: 1543 & 23 = 7, then 0x8000_0000
    out_ready = 1'b0;
    send(32'd7, ALU_AND);
    send(32'h8000_0000, ALU_SUB);
    check("bp_in_ready", 64'(in_ready),   64'd0);
    check("bp_result",   64'(out_result), 64'd7);
    idle(4);
    check("bp_hold_result", 64'(out_result), 64'd7);
    check("bp_hold_ready",  64'(in_ready),   64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_second_result", 64'(out_result), 64'h8000_0000);
    check("bp_second_neg",    64'(out_neg),    64'd1);
    drain("bp_drain");

    // Throughput: 16 back-to-back results with the consumer always ready
    ready_drops = 0;
    for (int i = 0; i < 16; i++) send(32'(i), ALU_ADD);
    check("tput_ready_drops", 64'(ready_drops), 64'd0);
    drain("tput_drain");

    // Reset mid-cycle with two entries held
    out_ready = 1'b0;
    send(32'h1234_5678, ALU_ADD);
    send(32'hFFFF_FFFF, ALU_SUB);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready",  64'(in_ready),  64'd1);
    check("midrst_outputs",   64'({out_op, out_result, out_zero, out_neg}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(3);
    check("postrst_out_valid", 64'(out_valid), 64'd0);

    // Random traffic: 1000 results with random gaps and random backpressure
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [31:0] f;
          int sel;
          sel = $urandom_range(0, 5);
          f = (sel == 0) ? 32'd0 : (sel == 1) ? (32'h8000_0000 | $urandom) : $urandom;
          idle($urandom_range(0, 1) == 0 ? 0 : $urandom_range(1, 2));
          send(f, 4'($urandom_range(0, 3)));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 2) != 0);
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    drain("rand_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
